// File: rtl/srm_pkg.sv
// Shared Simple RISC Machine constants: opcodes, sub-ops,
// the HALT word and the encoder FSM state type.
package srm_pkg;

    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_B    = 3'b001;
    localparam logic [2:0] OPC_BL   = 3'b010;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] BR_BX   = 2'b00;
    localparam logic [1:0] BR_BL   = 2'b11;
    localparam logic [1:0] OP_NONE = 2'b00;

    localparam logic [15:0] HALT_WORD = 16'hE000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FULL,
        S_DONE
    } state_t;

    // imm fits signed 5-bit when the upper bits copy bit 4
    function automatic logic imm5_ok(input logic [7:0] imm);
        return imm[7:5] == {3{imm[4]}};
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Field-tuple handshake plus instruction-memory write bus
// and status flags of the instruction encoder.
interface instruction_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        opcode;
    logic [1:0]        op;
    logic [2:0]        rn;
    logic [2:0]        rd;
    logic [2:0]        rm;
    logic [1:0]        shift;
    logic [2:0]        cond;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_write;
    logic [ADDR_W:0]   count;
    logic              err;
    logic              done;
    logic              full;

    modport master (
        output in_valid, opcode, op, rn, rd, rm,
        output shift, cond, imm,
        input  in_ready, mem_addr, mem_din, mem_write,
        input  count, err, done, full
    );

    modport slave (
        input  in_valid, opcode, op, rn, rd, rm,
        input  shift, cond, imm,
        output in_ready, mem_addr, mem_din, mem_write,
        output count, err, done, full
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields to a 16-bit machine
// word plus a legality flag. Don't-care fields come out 0.
module instr_pack
    import srm_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [1:0]  op,
    input  logic [2:0]  rn,
    input  logic [2:0]  rd,
    input  logic [2:0]  rm,
    input  logic [1:0]  shift,
    input  logic [2:0]  cond,
    input  logic [7:0]  imm,
    output logic [15:0] word,
    output logic        legal
);

    logic is_mov, is_alu, is_ldr, is_str;
    logic is_b, is_bl, is_halt, i5;

    assign is_mov  = opcode == OPC_MOV;
    assign is_alu  = opcode == OPC_ALU;
    assign is_ldr  = opcode == OPC_LDR;
    assign is_str  = opcode == OPC_STR;
    assign is_b    = opcode == OPC_B;
    assign is_bl   = opcode == OPC_BL;
    assign is_halt = opcode == OPC_HALT;
    assign i5      = imm5_ok(imm);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (1'b1)
            is_mov && op == MOV_IMM: begin
                word  = {OPC_MOV, MOV_IMM, rn, imm};
                legal = 1'b1;
            end
            is_mov && op == MOV_REG: begin
                word  = {OPC_MOV, MOV_REG, 3'b000, rd, shift, rm};
                legal = 1'b1;
            end
            is_alu && (op == ALU_ADD || op == ALU_AND): begin
                word  = {OPC_ALU, op, rn, rd, shift, rm};
                legal = 1'b1;
            end
            is_alu && op == ALU_CMP: begin
                word  = {OPC_ALU, ALU_CMP, rn, 3'b000, shift, rm};
                legal = 1'b1;
            end
            is_alu && op == ALU_MVN: begin
                word  = {OPC_ALU, ALU_MVN, 3'b000, rd, shift, rm};
                legal = 1'b1;
            end
            is_ldr && op == OP_NONE && i5: begin
                word  = {OPC_LDR, OP_NONE, rn, rd, imm[4:0]};
                legal = 1'b1;
            end
            is_str && op == OP_NONE && i5: begin
                word  = {OPC_STR, OP_NONE, rn, rd, imm[4:0]};
                legal = 1'b1;
            end
            is_b && op == OP_NONE: begin
                word  = {OPC_B, OP_NONE, cond, imm};
                legal = 1'b1;
            end
            is_bl && op == BR_BL: begin
                word  = {OPC_BL, BR_BL, 3'b111, imm};
                legal = 1'b1;
            end
            is_bl && op == BR_BX: begin
                word  = {OPC_BL, BR_BX, 3'b000, rd, 5'b00000};
                legal = 1'b1;
            end
            is_halt && op == OP_NONE: begin
                word  = HALT_WORD;
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Accepts field tuples, packs them and writes the words to
// consecutive instruction-memory addresses until full or HALT.
module instruction_encoder
    import srm_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    instruction_encoder_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            state;
    logic              ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       din_q;
    logic              wr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              done_q;
    logic              full_q;
    logic [15:0]       word;
    logic              legal;
    logic              accept;

    instr_pack u_pack (
        .opcode (bus.opcode),
        .op     (bus.op),
        .rn     (bus.rn),
        .rd     (bus.rd),
        .rm     (bus.rm),
        .shift  (bus.shift),
        .cond   (bus.cond),
        .imm    (bus.imm),
        .word   (word),
        .legal  (legal)
    );

    // clear must block acceptance in the same cycle
    assign bus.in_ready  = ready_q & ~clear;
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.mem_write = wr_q;
    assign bus.count     = count_q;
    assign bus.err       = err_q;
    assign bus.done      = done_q;
    assign bus.full      = full_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            wr_q    <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
        end else if (clear) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept && legal) begin
                        din_q   <= word;
                        wr_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= S_WRITE;
                    end else if (accept) begin
                        err_q <= 1'b1;
                    end
                end
                S_WRITE: begin
                    wr_q    <= 1'b0;
                    count_q <= count_q + 1'b1;
                    if (din_q == HALT_WORD) begin
                        done_q <= 1'b1;
                        full_q <= addr_q == LAST;
                        state  <= S_DONE;
                    end else if (addr_q == LAST) begin
                        full_q <= 1'b1;
                        state  <= S_FULL;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_FULL: ;
                S_DONE: ;
            endcase
        end
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Sequential packer that turns decoded instruction fields back into 16-bit Simple RISC Machine machine words and writes them into instruction memory at consecutive addresses. It is the inverse of the datapath's instruction decode path. It sits between a program source (test sequencer, host loader, UART front end) and the instruction RAM. Fields are accepted over a valid/ready handshake; illegal combinations are flagged and never written.

## Interface
- ADDR_W, 8, instruction-memory address width; depth = 2^ADDR_W words
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart: address to 0, clears done/full/err
- in_valid  in  1  field tuple present
- in_ready  out  1  encoder can accept a tuple this cycle
- opcode  in  3  instruction class
- op  in  2  sub-operation / ALUop
- rn, rd, rm  in  3 each  register numbers
- shift  in  2  shift code
- cond  in  3  branch condition
- imm  in  8  immediate; imm5 forms use imm[4:0]
- mem_addr  out  ADDR_W  write address
- mem_din  out  16  encoded word
- mem_write  out  1  one-cycle write strobe
- count  out  ADDR_W+1  words written since reset/clear
- err  out  1  sticky illegal-encoding flag
- done  out  1  HALT written
- full  out  1  last address written

## Operation
- Legal encodings (MSB first):
  - MOV imm is 110,10,rn,imm8.
  - MOV reg is 110,00,000,rd,shift,rm.
  - ADD/AND is 101,{00|10},rn,rd,shift,rm.
  - CMP is 101,01,rn,000,shift,rm.
  - MVN is 101,11,000,rd,shift,rm.
  - LDR is 011,00,rn,rd,imm5.
  - STR is 100,00,rn,rd,imm5.
  - B is 001,00,cond,imm8.
  - BL is 010,11,111,imm8.
  - BX is 010,00,000,rd,00000.
  - HALT is 111 followed by 13 zeros.
- Don't-care fields are forced to 0 regardless of input.
- imm5 forms require imm[7:5] == {3{imm[4]}}, i.e. the value is representable as signed 5-bit. Otherwise the tuple is illegal.
- Any other opcode/op pair is illegal.
- For an illegal tuple: it is accepted (handshake completes), err sets, nothing is written, address is unchanged.
- FSM states: IDLE, WRITE, FULL, DONE.
  - IDLE: in_ready=1. On a legal accepted tuple, register mem_din and go to WRITE. On an illegal tuple, set err and stay in IDLE.
  - WRITE: mem_write=1 and in_ready=0 for exactly one cycle. At the end of WRITE: count++. Then:
    - if the word was HALT, go to DONE;
    - else if mem_addr == 2^ADDR_W-1, go to FULL;
    - else mem_addr++ and return to IDLE.
  - FULL / DONE: in_ready=0; full or done held at 1 until clear or reset.
- HALT written to the last address: DONE takes priority; full also asserts.
- clear in any state: next state IDLE, mem_addr=0, count=0, err/done/full=0. A WRITE in progress still completes its strobe that cycle, but its count/address update is discarded.
- clear and in_valid in the same cycle: clear wins; the tuple is not accepted (in_ready is forced to 0 while clear=1).

## Timing
- Reset values: state IDLE, in_ready=1 after reset release, mem_addr=0, mem_din=0, mem_write=0, count=0, err=0, done=0, full=0.
- Accept at edge N; mem_write high during cycle N+1 with mem_addr/mem_din stable; next accept possible at edge N+2. Peak throughput is 1 word per 2 cycles.
- All outputs are registered. in_ready is a function of state and clear only, never of in_valid.
- Reset asserted mid-WRITE aborts immediately. mem_write drops asynchronously; no partial count.
- Inputs are sampled only on an accepting edge; field changes at other times are ignored.

## Structure
- Shared package srm_pkg holds:
  - opcode constants (OPC_MOV=3'b110, OPC_ALU=3'b101, OPC_LDR=3'b011, OPC_STR=3'b100, OPC_B=3'b001, OPC_BL=3'b010, OPC_HALT=3'b111);
  - ALU op codes;
  - the HALT word 16'hE000;
  - the FSM state encoding.
  The decoder side reuses the same opcode constants.
- One combinational sub-module, instr_pack: fields in, {word[15:0], legal} out. The FSM, counters and sticky flags stay in instruction_encoder.

## Test plan
- Reset, then MOV rn=0 imm=8'h07 → mem_write one cycle after accept, mem_addr=0, mem_din=16'hD007, count=1.
- ADD rn=1 rd=2 shift=01 rm=0, then LDR rn=1 rd=3 imm=8'hFF back-to-back → words 16'hA148 at addr 0 and 16'h617F at addr 1; in_ready low during each WRITE.
- LDR with imm=8'h10 (not signed-5), then opcode=000 → err=1 after the first, no mem_write for either, mem_addr stays 0. A following legal tuple writes at addr 0.
- ADDR_W=2: four legal MOVs → addresses 0..3, full=1 after the 4th, in_ready=0. A fifth in_valid is not accepted. clear → addr 0, full=0, count=0.
- HALT at addr 2 → mem_din=16'hE000, done=1, in_ready=0. clear asserted together with in_valid → tuple not accepted.
- reset_n pulsed low during WRITE → mem_write drops in the same cycle, all outputs return to reset values.
